// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core.
// The core's d_mem_* bus reads the array combinationally and writes it on the rising edge.
// After every reset the array is zero-filled. A host port can preload and read back words.
module dmem_responder #(
  parameter int unsigned d_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   d_mem_we,
  input  logic [d_addr_bits-1:0] d_mem_addr,
  inout  wire  [63:0]            d_mem_data,
  output logic                   ready,
  input  logic                   host_we,
  input  logic                   host_re,
  input  logic [d_addr_bits-1:0] host_addr,
  input  logic [63:0]            host_wdata,
  output logic [63:0]            host_rdata,
  output logic                   host_rvalid,
  output logic                   host_collide
);

  localparam int unsigned Depth = 2 ** d_addr_bits;
  // One spare bit so the counter never wraps, even transiently
  localparam int unsigned CntW = d_addr_bits + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Depth - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic {
    StClear = 1'b0,
    StServe = 1'b1
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [63:0]     mem [Depth];

  logic serve;
  logic clear_last;
  logic core_wr;
  logic host_wr;
  logic host_rd;
  logic collide;
  logic bus_oe;

  // Decode of the current cycle's accesses; nothing is honoured until zero-fill completes
  always_comb begin
    serve      = (state_q == StServe);
    clear_last = (cnt_q == CntLast);
    core_wr    = serve & d_mem_we;
    host_wr    = serve & host_we;
    host_rd    = serve & host_re;
    collide    = core_wr & host_wr & (host_addr == d_mem_addr);
    bus_oe     = serve & ~d_mem_we;
  end

  // Asynchronous array read so a load completes in the same cycle; bus released on writes
  assign d_mem_data = bus_oe ? mem[d_mem_addr] : 64'bz;

  // Control FSM: zero-fill sweep, then serve; host-port outputs registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StClear;
      cnt_q        <= '0;
      ready        <= 1'b0;
      host_rdata   <= '0;
      host_rvalid  <= 1'b0;
      host_collide <= 1'b0;
    end else begin
      host_rvalid  <= host_rd;
      host_collide <= collide;
      // Pre-edge contents, so a same-cycle host or core write is not seen
      if (host_rd) begin
        host_rdata <= mem[host_addr];
      end
      unique case (state_q)
        StClear: begin
          cnt_q <= cnt_q + CntOne;
          if (clear_last) begin
            state_q <= StServe;
            ready   <= 1'b1;
          end
        end
        StServe: begin
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Array writes: zero-fill during CLEAR, otherwise host then core (core wins on same address)
  always_ff @(posedge clk) begin
    if (!serve) begin
      mem[cnt_q[d_addr_bits-1:0]] <= '0;
    end else begin
      if (host_wr) begin
        mem[host_addr] <= host_wdata;
      end
      if (core_wr) begin
        mem[d_mem_addr] <= d_mem_data;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core: the slave end of the core's `d_mem_*` bus. Holds a 2^`d_addr_bits` × 64-bit array, drives the bidirectional data bus on reads, captures it on writes, and zero-fills the array after every reset. A secondary host port lets the bench/loader preload and read back words while the core runs.

## Interface

- `d_addr_bits`, 6, word-address width; depth N = 2^`d_addr_bits`
- `clk`  input  1  clock, rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `d_mem_we`  input  1  core write enable
- `d_mem_addr`  input  `d_addr_bits`  core word address
- `d_mem_data`  inout  64  core data bus; driven by this block only on reads
- `ready`  output  1  high once zero-fill is complete; core must not access memory while low
- `host_we`  input  1  host write strobe
- `host_re`  input  1  host read strobe
- `host_addr`  input  `d_addr_bits`  host word address
- `host_wdata`  input  64  host write data
- `host_rdata`  output  64  host read data, registered
- `host_rvalid`  output  1  one-cycle pulse qualifying `host_rdata`
- `host_collide`  output  1  one-cycle pulse: host write lost to a same-address core write

## Operation

- FSM states: CLEAR, SERVE. Reset (async) forces CLEAR, clear counter = 0.
- CLEAR: each cycle write 0 to `mem[cnt]`, `cnt <= cnt+1`; after writing address N-1 go to SERVE. Counter is `d_addr_bits`+1 wide; terminal at cnt == N-1, no wrap.
- In CLEAR: core writes ignored, `d_mem_data` released (Z), host strobes ignored (no `host_rvalid`, no `host_collide`).
- SERVE: `ready` = 1. Stays in SERVE until reset.
- Core read (SERVE, `d_mem_we`=0): `d_mem_data` = `mem[d_mem_addr]`, combinational (asynchronous array read) so single-cycle load completes in the same cycle.
- Core write (SERVE, `d_mem_we`=1): `d_mem_data` released; `mem[d_mem_addr] <= d_mem_data` at rising edge.
- Bus driver enable = (state==SERVE) && !`d_mem_we`; otherwise Z. Never driven in the same cycle as a core write.
- Host write (SERVE): `mem[host_addr] <= host_wdata` at rising edge.
- Host read (SERVE): `host_rdata <= mem[host_addr]` at rising edge, `host_rvalid` <= 1 for one cycle. Value is pre-edge contents (read-before-write for same-cycle writes).
- `host_we` and `host_re` together: both performed; read returns old data.
- Same-cycle core write and host write, same address: core data stored, `host_collide` pulses 1 cycle. Different addresses: both stored.
- Core read of an address being host-written this cycle: returns old value; new value visible the following cycle.

## Timing

- Reset values: `ready`=0, `host_rdata`=0, `host_rvalid`=0, `host_collide`=0, `d_mem_data`=Z, state=CLEAR, cnt=0.
- Zero-fill: N cycles after first rising edge with `rst_n`=1; `ready` rises on edge N (after `mem[N-1]` cleared). N=64 at default.
- Core read latency: 0 cycles (combinational from `d_mem_addr`). Core write: visible to reads the cycle after the edge.
- Host read latency: 1 cycle; `host_rvalid` back-to-back capable (one read per cycle).
- Reset mid-CLEAR or mid-SERVE: immediate return to CLEAR, `ready`=0 and bus Z asynchronously; array content undefined until new zero-fill completes; any in-flight host read is dropped (`host_rvalid` 0).

## Test plan

- Reset release, N=64 -> `ready` low for 64 cycles, high on cycle 64; core reads of addresses 0, 31, 63 return 0; bus Z throughout CLEAR.
- Core write 0xDEAD_BEEF_0123_4567 to addr 5, then read addr 5 -> same cycle after write edge bus shows value; bus Z during write cycle (checked with weak pull on bench).
- Host write 0x1111 to addr 10, next cycle `host_re` addr 10 -> `host_rvalid` one cycle later, `host_rdata`=0x1111; core read addr 10 = 0x1111.
- Same cycle core write 0xAAAA and host write 0xBBBB to addr 3 -> `host_collide` pulses once, `mem[3]`=0xAAAA; repeat with addr 3 vs 4 -> no collide, both stored.
- Host write during CLEAR (cycle 10, addr 60, 0x5555) -> ignored; after `ready`, addr 60 reads 0.
- Write addr 7 = 0x77, assert `rst_n`=0 mid-SERVE for 2 cycles -> `ready` drops same cycle, bus Z; after new 64-cycle fill, addr 7 reads 0.
